comnet_master: RTL and testbench

Serial command master that drives the SDa/SCl link into the comnet slave and collects its RDa return data. It accepts one parallel request at a time (rw, 8-bit register address, 32-bit write data) and serialises it as start, 42 bits, stop. For reads it then clocks back the 32-bit register value. It sits on the controller side of the link, directly upstream of comnet, and produces the frames comnet's start detector and 42-bit shifter consume.

---
 rtl/comnet_master.sv | 177 +++++++++++++++++
 tb/tb_comnet_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comnet_master.sv
// comnet_master: serial command master for the comnet SDa/SCl/RDa link.
// Takes one parallel request (rw, addr, wdata) at a time. It sends a start
// condition, a 42-bit frame MSB first and a stop condition. For reads it waits
// GAP idle cycles, gives one load pulse, then clocks 32 return bits in from RDa.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   req_valid/req_ready      request handshake (accept on valid & ready)
//   req_rw/addr/wdata        request payload (1=read)
//   rsp_valid/rsp_rdata      end-of-transaction pulse / last read data
//   busy                     transaction in progress
//   SDa, SCl                 serial data/clock to slave
//   RDa                      serial return data from slave
module comnet_master #(
    parameter int unsigned HALF = 4,
    parameter int unsigned GAP  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        SDa,
    output logic        SCl,
    input  logic        RDa
);

    localparam int unsigned CNT_MAX = (HALF > GAP) ? HALF : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam int unsigned FW      = 42;
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);

    typedef enum logic [3:0] {
        IDLE, START, BIT_LO, BIT_HI, STOP_LO, STOP_HI,
        GAPW, LD_LO, LD_HI, RD_LO, RD_HI, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            rw_q, rw_d;
    logic [30:0]     shreg_q, shreg_d;
    logic [31:0]     rdata_d;
    logic            sda_d, scl_d, rsp_valid_d, ready_d;
    logic            half_done;

    assign half_done = (cnt_q == HALF_END);

    // Next state, datapath and next registered outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        rw_d        = rw_q;
        shreg_d     = shreg_q;
        rdata_d     = rsp_rdata;
        sda_d       = 1'b1;
        scl_d       = 1'b1;
        rsp_valid_d = 1'b0;
        ready_d     = 1'b0;
        cnt_d       = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    frame_d = {req_rw, req_addr, req_wdata, 1'b0};
                    rw_d    = req_rw;
                    state_d = START;
                end
            end
            START: begin
                if (half_done) begin
                    idx_d   = 6'd41;
                    state_d = BIT_LO;
                end
            end
            BIT_LO:  if (half_done) state_d = BIT_HI;
            BIT_HI: begin
                if (half_done) begin
                    if (idx_q == 6'd0) begin
                        state_d = STOP_LO;
                    end else begin
                        idx_d   = idx_q - 6'd1;
                        state_d = BIT_LO;
                    end
                end
            end
            STOP_LO: if (half_done) state_d = STOP_HI;
            STOP_HI: if (half_done) state_d = GAPW;
            GAPW:    if (cnt_q == GAP_END) state_d = rw_q ? LD_LO : DONE;
            LD_LO:   if (half_done) state_d = LD_HI;
            LD_HI: begin
                if (half_done) begin
                    idx_d   = 6'd31;
                    state_d = RD_LO;
                end
            end
            RD_LO:   if (half_done) state_d = RD_HI;
            RD_HI: begin
                // Sample RDa on the last cycle of the high phase, MSB first
                if (half_done) begin
                    shreg_d = {shreg_q[29:0], RDa};
                    if (idx_q == 6'd0) begin
                        rdata_d = {shreg_q, RDa};
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - 6'd1;
                        state_d = RD_LO;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Phase counter restarts on every state entry, parked in IDLE
        if (state_d == state_q && state_d != IDLE)
            cnt_d = cnt_q + CW'(1);

        // Line levels follow the state being entered so they are registered
        case (state_d)
            START, STOP_HI: sda_d = 1'b0;
            STOP_LO: begin
                sda_d = 1'b0;
                scl_d = 1'b0;
            end
            BIT_LO: begin
                sda_d = frame_d[idx_d];
                scl_d = 1'b0;
            end
            BIT_HI:        sda_d = frame_d[idx_d];
            LD_LO, RD_LO:  scl_d = 1'b0;
            default: ;
        endcase

        rsp_valid_d = (state_d == DONE);
        ready_d     = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            rw_q      <= 1'b0;
            shreg_q   <= '0;
            SDa       <= 1'b1;
            SCl       <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            rw_q      <= rw_d;
            shreg_q   <= shreg_d;
            SDa       <= sda_d;
            SCl       <= scl_d;
            req_ready <= ready_d;
            busy      <= ~ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_comnet_master.sv
// Testbench for comnet_master: two instances (HALF=4/GAP=16 and HALF=2/GAP=2),
// a line monitor with a behavioural comnet slave, and per-feature test tasks.
module tb_comnet_master;

    localparam int unsigned H0 = 4, G0 = 16, H1 = 2, G1 = 2;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        v      [2];
    logic        rw     [2];
    logic [7:0]  addr   [2];
    logic [31:0] wd     [2];
    logic        ready  [2];
    logic        rv     [2];
    logic [31:0] rdata  [2];
    logic        busy   [2];
    logic        sda    [2];
    logic        scl    [2];
    logic        rda    [2] = '{1'b1, 1'b1};

    always #5 clk = ~clk;

    comnet_master #(.HALF(H0), .GAP(G0)) dut (
        .clk(clk), .rst(rst[0]), .req_valid(v[0]), .req_ready(ready[0]),
        .req_rw(rw[0]), .req_addr(addr[0]), .req_wdata(wd[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .busy(busy[0]),
        .SDa(sda[0]), .SCl(scl[0]), .RDa(rda[0]));

    comnet_master #(.HALF(H1), .GAP(G1)) dut2 (
        .clk(clk), .rst(rst[1]), .req_valid(v[1]), .req_ready(ready[1]),
        .req_rw(rw[1]), .req_addr(addr[1]), .req_wdata(wd[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .busy(busy[1]),
        .SDa(sda[1]), .SCl(scl[1]), .RDa(rda[1]));

    // ---------------- line monitor + behavioural slave ----------------
    int          cyc = 0;
    int          rises [2]   = '{default: 0};
    int          starts[2]   = '{default: 0};
    int          stops [2]   = '{default: 0};
    int          hi_tog[2]   = '{default: 0};
    int          rspn  [2]   = '{default: 0};
    int          lo_bad[2]   = '{default: 0};
    int          hi_half[2]  = '{default: 0};
    int          run   [2]   = '{default: 0};
    bit          from_rise[2] = '{default: 1'b0};
    int          last_rsp[2] = '{default: -1000000};
    int          min_gap[2]  = '{default: 1000000};
    logic        p_sda [2]   = '{1'b1, 1'b1};
    logic        p_scl [2]   = '{1'b1, 1'b1};
    logic [63:0] fsh   [2]   = '{default: 64'd0};
    logic [63:0] stop_frame[2] = '{default: 64'd0};
    bit          armed [2]   = '{default: 1'b0};
    bit          loaded[2]   = '{default: 1'b0};
    int          sbit  [2]   = '{default: 31};
    logic [31:0] rd_word[2]  = '{default: 32'd0};

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int hh;
            hh = (d == 0) ? int'(H0) : int'(H1);
            if (rv[d]) begin
                rspn[d]++;
                last_rsp[d] = cyc;
            end
            // SDa change while SCl stays high: start (fall) or stop (rise)
            if (p_scl[d] && scl[d] && (p_sda[d] != sda[d])) begin
                hi_tog[d]++;
                if (!sda[d]) begin
                    starts[d]++;
                    fsh[d] = 64'd0;
                    armed[d] = 1'b0;
                    loaded[d] = 1'b0;
                    if (cyc - last_rsp[d] < min_gap[d]) min_gap[d] = cyc - last_rsp[d];
                end else begin
                    stops[d]++;
                    stop_frame[d] = fsh[d];
                    armed[d] = 1'b1;
                    loaded[d] = 1'b0;
                    sbit[d] = 31;
                end
            end
            if (p_scl[d] != scl[d]) begin
                if (!p_scl[d] && run[d] != hh) lo_bad[d]++;
                if (p_scl[d] && from_rise[d] && run[d] == hh) hi_half[d]++;
                from_rise[d] = scl[d];
                run[d] = 1;
                if (scl[d]) begin
                    rises[d]++;
                    fsh[d] = {fsh[d][62:0], sda[d]};
                    if (armed[d] && !loaded[d]) loaded[d] = 1'b1;
                end else if (loaded[d] && sbit[d] >= 0) begin
                    rda[d] = rd_word[d][sbit[d]];
                    sbit[d]--;
                end
            end else begin
                run[d]++;
            end
            p_sda[d] = sda[d];
            p_scl[d] = scl[d];
        end
    end

    // ---------------- bench bookkeeping ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_read[2] = '{default: 32'd0};

    typedef struct {
        bit          timeout;
        int          lat;
        logic [31:0] rdata;
        int          rises, tog, stops, rsp, lo_bad, hi_half;
        logic [63:0] frame;
    } obs_t;

    function automatic int exp_lat(input int d, input bit r);
        int h, g;
        h = (d == 0) ? int'(H0) : int'(H1);
        g = (d == 0) ? int'(G0) : int'(G1);
        // start + 42 bits + stop + gap + done, plus load pulse and 32 read pulses
        return h + 84 * h + 2 * h + g + 1 + (r ? 66 * h : 0);
    endfunction

    function automatic logic [63:0] exp_frame(input bit r, input logic [7:0] a, input logic [31:0] w);
        logic [42:0] f;
        f = {r, a, w, 1'b0, 1'b0};
        return 64'(f);
    endfunction

    // Drive one request and collect what the monitor saw; no checking here.
    task automatic do_txn(input int d, input bit r, input logic [7:0] a,
                          input logic [31:0] w, input logic [31:0] word, output obs_t o);
        int r0, t0, s0, n0, l0, h0, k;
        o = '{timeout: 1'b0, lat: 0, rdata: 32'd0, rises: 0, tog: 0, stops: 0,
              rsp: 0, lo_bad: 0, hi_half: 0, frame: 64'd0};
        rd_word[d] = word;
        @(negedge clk);
        k = 0;
        while (!ready[d] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!ready[d]) begin
            o.timeout = 1'b1;
            return;
        end
        r0 = rises[d]; t0 = hi_tog[d]; s0 = stops[d]; n0 = rspn[d];
        l0 = lo_bad[d]; h0 = hi_half[d];
        v[d] = 1'b1; rw[d] = r; addr[d] = a; wd[d] = w;
        @(negedge clk);
        v[d] = 1'b0; rw[d] = 1'($urandom); addr[d] = 8'($urandom); wd[d] = $urandom;
        k = 1;
        while (!rv[d] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!rv[d]) begin
            o.timeout = 1'b1;
            return;
        end
        o.lat = k;
        o.rdata = rdata[d];
        repeat (3) @(negedge clk);
        o.rises = rises[d] - r0; o.tog = hi_tog[d] - t0; o.stops = stops[d] - s0;
        o.rsp = rspn[d] - n0; o.lo_bad = lo_bad[d] - l0; o.hi_half = hi_half[d] - h0;
        o.frame = stop_frame[d];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; v[d] = 1'b0; rw[d] = 1'b0; addr[d] = 8'd0; wd[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks += 6;
            if (sda[d] !== 1'b1) begin n_fail++; $display("FAIL reset_sda[%0d] got %b want 1", d, sda[d]); end
            if (scl[d] !== 1'b1) begin n_fail++; $display("FAIL reset_scl[%0d] got %b want 1", d, scl[d]); end
            if (ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 1", d, ready[d]); end
            if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", d, busy[d]); end
            if (rv[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d] got %b want 0", d, rv[d]); end
            if (rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d] got %h want 0", d, rdata[d]); end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        obs_t o;
        do_txn(0, 1'b0, 8'h5A, 32'hDEADBEEF, 32'h0, o);
        n_checks += 7;
        if (o.timeout) begin n_fail++; $display("FAIL write_timeout got 1 want 0"); end
        if (o.frame !== exp_frame(1'b0, 8'h5A, 32'hDEADBEEF)) begin n_fail++; $display("FAIL write_frame got %h want %h", o.frame, exp_frame(1'b0, 8'h5A, 32'hDEADBEEF)); end
        if (o.rises != 43) begin n_fail++; $display("FAIL write_rises got %0d want 43", o.rises); end
        if (o.stops != 1) begin n_fail++; $display("FAIL write_stop got %0d want 1", o.stops); end
        if (o.rsp != 1) begin n_fail++; $display("FAIL write_rsp_pulses got %0d want 1", o.rsp); end
        if (o.rdata !== last_read[0]) begin n_fail++; $display("FAIL write_rdata_held got %h want %h", o.rdata, last_read[0]); end
        if (o.lat != 365) begin n_fail++; $display("FAIL write_latency got %0d want 365", o.lat); end
    endtask

    task automatic test_read();
        obs_t o;
        do_txn(0, 1'b1, 8'h03, 32'hA5A5_0F0F, 32'h12345678, o);
        n_checks += 5;
        if (o.timeout) begin n_fail++; $display("FAIL read_timeout got 1 want 0"); end
        if (o.rdata !== 32'h12345678) begin n_fail++; $display("FAIL read_rdata got %h want 12345678", o.rdata); end
        if (o.rises != 76) begin n_fail++; $display("FAIL read_rises got %0d want 76", o.rises); end
        if (o.lat != 365 + 264) begin n_fail++; $display("FAIL read_latency got %0d want %0d", o.lat, 365 + 264); end
        if (o.frame !== exp_frame(1'b1, 8'h03, 32'hA5A5_0F0F)) begin n_fail++; $display("FAIL read_frame got %h want %h", o.frame, exp_frame(1'b1, 8'h03, 32'hA5A5_0F0F)); end
        last_read[0] = 32'h12345678;
    endtask

    task automatic test_random_mix(input int d, input int n);
        obs_t        o;
        bit          r;
        logic [7:0]  a;
        logic [31:0] w, word, exp_rd;
        for (int i = 0; i < n; i++) begin
            r = 1'($urandom_range(0, 1)); a = 8'($urandom); w = $urandom; word = $urandom;
            do_txn(d, r, a, w, word, o);
            exp_rd = r ? word : last_read[d];
            n_checks += 7;
            if (o.timeout) begin n_fail++; $display("FAIL mix%0d_%0d_timeout got 1 want 0", d, i); end
            if (o.tog != 2) begin n_fail++; $display("FAIL mix%0d_%0d_sda_while_scl_high got %0d want 2", d, i, o.tog); end
            if (o.rdata !== exp_rd) begin n_fail++; $display("FAIL mix%0d_%0d_rdata got %h want %h", d, i, o.rdata, exp_rd); end
            if (o.frame !== exp_frame(r, a, w)) begin n_fail++; $display("FAIL mix%0d_%0d_frame got %h want %h", d, i, o.frame, exp_frame(r, a, w)); end
            if (o.rises != (r ? 76 : 43)) begin n_fail++; $display("FAIL mix%0d_%0d_rises got %0d want %0d", d, i, o.rises, r ? 76 : 43); end
            if (o.lat != exp_lat(d, r)) begin n_fail++; $display("FAIL mix%0d_%0d_latency got %0d want %0d", d, i, o.lat, exp_lat(d, r)); end
            if (o.rsp != 1) begin n_fail++; $display("FAIL mix%0d_%0d_rsp_pulses got %0d want 1", d, i, o.rsp); end
            last_read[d] = exp_rd;
        end
    endtask

    task automatic test_back_to_back();
        bit          qr[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0]  qa[3];
        logic [31:0] qw[3];
        logic [31:0] got_rd[3];
        logic [31:0] exp_rd;
        int          i, got, k, s0, n0, bad_ready;
        bit          pend;
        for (int j = 0; j < 3; j++) begin qa[j] = 8'($urandom); qw[j] = $urandom; end
        rd_word[0] = $urandom;
        @(negedge clk);
        s0 = starts[0]; n0 = rspn[0];
        i = 0; got = 0; k = 0; pend = 1'b0; bad_ready = 0;
        v[0] = 1'b1; rw[0] = qr[0]; addr[0] = qa[0]; wd[0] = qw[0];
        while ((i < 3 || got < 3) && k < 5000) begin
            if (rv[0] && got < 3) begin got_rd[got] = rdata[0]; got++; end
            pend = (i < 3) && ready[0];
            @(negedge clk);
            k++;
            if (pend) begin
                if (ready[0]) bad_ready++;
                i++;
                if (i < 3) begin rw[0] = qr[i]; addr[0] = qa[i]; wd[0] = qw[i]; end
                else v[0] = 1'b0;
            end
        end
        v[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (got != 3 || i != 3) begin n_fail++; $display("FAIL b2b_count got %0d/%0d want 3/3", i, got); end
        if (starts[0] - s0 != 3) begin n_fail++; $display("FAIL b2b_starts got %0d want 3", starts[0] - s0); end
        if (rspn[0] - n0 != 3) begin n_fail++; $display("FAIL b2b_rsp got %0d want 3", rspn[0] - n0); end
        if (bad_ready != 0) begin n_fail++; $display("FAIL b2b_ready_after_accept got %0d want 0", bad_ready); end
        if (min_gap[0] != 2) begin n_fail++; $display("FAIL b2b_idle_gap got %0d want 2", min_gap[0]); end
        exp_rd = last_read[0];
        for (int j = 0; j < 3; j++) begin
            if (qr[j]) exp_rd = rd_word[0];
            if (got_rd[j] !== exp_rd) begin n_fail++; $display("FAIL b2b_rdata%0d got %h want %h", j, got_rd[j], exp_rd); end
        end
        last_read[0] = rd_word[0];
    endtask

    task automatic test_reset_midframe();
        obs_t o;
        int   r0, n0, k;
        rd_word[0] = 32'hCAFE_F00D;
        @(negedge clk);
        r0 = rises[0]; n0 = rspn[0];
        v[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h44; wd[0] = 32'h1111_2222;
        @(negedge clk);
        v[0] = 1'b0;
        k = 0;
        while (rises[0] - r0 < 22 && k < 2000) begin @(negedge clk); k++; end
        n_checks += 1;
        if (rises[0] - r0 < 22) begin n_fail++; $display("FAIL midrst_reach_bit20 got %0d rises want 22", rises[0] - r0); end
        #2 rst[0] = 1'b1;
        #1;
        n_checks += 3;
        if (sda[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_sda got %b want 1", sda[0]); end
        if (scl[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_scl got %b want 1", scl[0]); end
        if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", ready[0]); end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        repeat (700) @(negedge clk);
        last_read[0] = 32'd0;
        n_checks += 2;
        if (rspn[0] - n0 != 0) begin n_fail++; $display("FAIL midrst_no_rsp got %0d want 0", rspn[0] - n0); end
        if (rdata[0] !== 32'd0) begin n_fail++; $display("FAIL midrst_rdata got %h want 0", rdata[0]); end
        do_txn(0, 1'b1, 8'h10, 32'h0, 32'h0BAD_BEEF, o);
        n_checks += 3;
        if (o.timeout) begin n_fail++; $display("FAIL midrst_next_timeout got 1 want 0"); end
        if (o.rdata !== 32'h0BAD_BEEF) begin n_fail++; $display("FAIL midrst_next_rdata got %h want 0badbeef", o.rdata); end
        if (o.lat != exp_lat(0, 1'b1)) begin n_fail++; $display("FAIL midrst_next_latency got %0d want %0d", o.lat, exp_lat(0, 1'b1)); end
        last_read[0] = 32'h0BAD_BEEF;
    endtask

    task automatic test_small_params();
        obs_t o;
        do_txn(1, 1'b1, 8'h7E, 32'h0000_FFFF, 32'hFFFF0000, o);
        n_checks += 6;
        if (o.timeout) begin n_fail++; $display("FAIL small_timeout got 1 want 0"); end
        if (o.rdata !== 32'hFFFF0000) begin n_fail++; $display("FAIL small_rdata got %h want ffff0000", o.rdata); end
        if (o.rises != 76) begin n_fail++; $display("FAIL small_rises got %0d want 76", o.rises); end
        if (o.lo_bad != 0) begin n_fail++; $display("FAIL small_low_phase got %0d bad want 0", o.lo_bad); end
        // 42 bit highs + load high + 31 read highs that end in a fall
        if (o.hi_half != 74) begin n_fail++; $display("FAIL small_high_phase got %0d want 74", o.hi_half); end
        if (o.lat != exp_lat(1, 1'b1)) begin n_fail++; $display("FAIL small_latency got %0d want %0d", o.lat, exp_lat(1, 1'b1)); end
        last_read[1] = 32'hFFFF0000;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random_mix(0, 6);
        test_back_to_back();
        test_reset_midframe();
        test_small_params();
        test_random_mix(1, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
